irq_timer_ctrl: RTL and testbench

- Machine-level interrupt source block sitting directly upstream of the pipelined RISC-V core.
- Drives the core's 2-bit interrupt input:
  - bit 0 = external interrupt (MEIP).
  - bit 1 = timer interrupt (MTIP).
- Contains an external-line synchronizer with edge latch, a prescaled free-running mtime counter with mtimecmp compare, and a small memory-mapped register file written by the core's load/store path.

---
 rtl/irq_timer_ctrl_if.sv | 21 ++
 rtl/irq_timer_ctrl.sv | 123 ++++++++++++
 tb/tb_irq_timer_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_timer_ctrl_if.sv
// Core load/store register-access bus into irq_timer_ctrl; reads combinational, writes on clk edge.
// No backpressure: every strobe completes in its own cycle.
interface irq_timer_ctrl_if #(
    parameter int TIMER_W = 32
);
    logic               bus_sel_i;
    logic               bus_we_i;
    logic [3:0]         bus_addr_i;
    logic [TIMER_W-1:0] bus_wdata_i;
    logic [TIMER_W-1:0] bus_rdata_o;

    modport master (
        output bus_sel_i, bus_we_i, bus_addr_i, bus_wdata_i,
        input  bus_rdata_o
    );

    modport slave (
        input  bus_sel_i, bus_we_i, bus_addr_i, bus_wdata_i,
        output bus_rdata_o
    );
endinterface

// File: rtl/irq_timer_ctrl.sv
// MEIP/MTIP source: ext-line sync + edge latch, prescaled mtime/mtimecmp; 1-cycle registered irq output.
// No backpressure; IRQ_EXT_LEVEL_EN makes the external path level-sensitive instead of edge-latched.
module irq_timer_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32,
    parameter int PRESCALE    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_irq_i,
    irq_timer_ctrl_if.slave      bus,
    input  logic [1:0]           intr_ack_i,
    output logic [1:0]           interrupt
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_sync;
    logic                   ext_pend;
    logic                   timer_pend;
    logic [TIMER_W-1:0]     mtime;
    logic [TIMER_W-1:0]     mtimecmp;
    logic [1:0]             ie;
    logic [PW-1:0]          pre_cnt;
    logic                   tick;
    logic                   wr_en;
    logic                   wr_mtime;
    logic                   wr_mtimecmp;
    logic                   wr_ie;
    logic                   wr_pend;

    assign wr_en       = bus.bus_sel_i & bus.bus_we_i;
    assign wr_mtime    = wr_en & (bus.bus_addr_i[3:2] == 2'd0);
    assign wr_mtimecmp = wr_en & (bus.bus_addr_i[3:2] == 2'd1);
    assign wr_ie       = wr_en & (bus.bus_addr_i[3:2] == 2'd2);
    assign wr_pend     = wr_en & (bus.bus_addr_i[3:2] == 2'd3);

    assign ext_sync   = sync_q[SYNC_STAGES-1];
    assign tick       = (pre_cnt == PW'(PRESCALE - 1));
    assign timer_pend = (mtime >= mtimecmp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
        end
    end

`ifdef IRQ_EXT_LEVEL_EN
    assign ext_pend = ext_sync;

    logic unused_level;
    assign unused_level = ^{intr_ack_i, wr_pend};
`else
    logic hist_q;
    logic ext_rise;
    logic ext_clr;

    assign ext_rise = ext_sync & ~hist_q;
    assign ext_clr  = (wr_pend & bus.bus_wdata_i[0]) | intr_ack_i[0];

    // A new edge in the same cycle as a clear must not be lost, so set dominates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q   <= 1'b0;
            ext_pend <= 1'b0;
        end else begin
            hist_q   <= ext_sync;
            ext_pend <= ext_rise | (ext_pend & ~ext_clr);
        end
    end

    logic unused_edge;
    assign unused_edge = intr_ack_i[1];
`endif

    // Bus write to MTIME overrides the increment; the prescaler keeps running regardless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            ie       <= 2'b00;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (wr_mtime) begin
                mtime <= bus.bus_wdata_i;
            end else if (tick) begin
                mtime <= mtime + 1'b1;
            end
            if (wr_mtimecmp) begin
                mtimecmp <= bus.bus_wdata_i;
            end
            if (wr_ie) begin
                ie <= bus.bus_wdata_i[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupt <= 2'b00;
        end else begin
            interrupt <= {timer_pend & ie[1], ext_pend & ie[0]};
        end
    end

    always_comb begin
        bus.bus_rdata_o = '0;
        if (bus.bus_sel_i) begin
            case (bus.bus_addr_i[3:2])
                2'd0:    bus.bus_rdata_o = mtime;
                2'd1:    bus.bus_rdata_o = mtimecmp;
                2'd2:    bus.bus_rdata_o[1:0] = ie;
                default: bus.bus_rdata_o[1:0] = {timer_pend, ext_pend};
            endcase
        end
    end

    logic unused_addr;
    assign unused_addr = ^bus.bus_addr_i[1:0];
endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl (default edge-latched build, PRESCALE=1, SYNC_STAGES=2).
// Inputs change and outputs are sampled on the falling edge; registers read combinationally.
module tb_irq_timer_ctrl;
    localparam logic [3:0] A_MTIME = 4'h0;
    localparam logic [3:0] A_CMP   = 4'h4;
    localparam logic [3:0] A_IE    = 4'h8;
    localparam logic [3:0] A_PEND  = 4'hC;

    logic       clk;
    logic       reset;
    logic       ext_irq_i;
    logic [1:0] intr_ack_i;
    logic [1:0] interrupt;
    int         checks;
    int         failures;

    irq_timer_ctrl_if #(.TIMER_W(32)) bus ();

    irq_timer_ctrl #(
        .SYNC_STAGES(2),
        .TIMER_W    (32),
        .PRESCALE   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ext_irq_i (ext_irq_i),
        .bus       (bus),
        .intr_ack_i(intr_ack_i),
        .interrupt (interrupt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic [1:0] exp);
        chk(tag, {30'd0, interrupt}, {30'd0, exp});
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus.bus_sel_i  = 1'b1;
        bus.bus_we_i   = 1'b0;
        bus.bus_addr_i = a;
        #1;
        chk(tag, bus.bus_rdata_o, exp);
        bus.bus_sel_i  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.bus_sel_i   = 1'b1;
        bus.bus_we_i    = 1'b1;
        bus.bus_addr_i  = a;
        bus.bus_wdata_i = d;
        @(negedge clk);
        bus.bus_sel_i   = 1'b0;
        bus.bus_we_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        ext_irq_i       = 1'b0;
        intr_ack_i      = 2'b00;
        bus.bus_sel_i   = 1'b0;
        bus.bus_we_i    = 1'b0;
        bus.bus_addr_i  = 4'h0;
        bus.bus_wdata_i = 32'h0;

        // Power-on reset values
        idle(2);
        chk_irq("por_irq", 2'b00);
        rd("por_mtime", A_MTIME, 32'h0);
        rd("por_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("por_ie", A_IE, 32'h0);
        rd("por_pend", A_PEND, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Build up state, then reset mid-count
        wr(A_IE, 32'h3);
        wr(A_MTIME, 32'h25);
        ext_irq_i = 1'b1;
        idle(1);
        ext_irq_i = 1'b0;
        idle(3);
        chk_irq("mid_irq", 2'b01);
        rd("mid_mtime", A_MTIME, 32'h29);
        rd("mid_pend", A_PEND, 32'h1);
        idle(1);
        reset = 1'b0;
        #1;
        chk_irq("rst_async_irq", 2'b00);
        rd("rst_async_mtime", A_MTIME, 32'h0);
        rd("rst_async_pend", A_PEND, 32'h0);
        rd("rst_async_ie", A_IE, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        chk_irq("rel_irq", 2'b00);
        rd("rel_mtime", A_MTIME, 32'h0);
        rd("rel_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rel_ie", A_IE, 32'h0);
        rd("rel_pend", A_PEND, 32'h0);
        @(negedge clk);

        // External edge latency and acknowledge
        wr(A_IE, 32'h1);
        ext_irq_i = 1'b1;
        idle(1);
        ext_irq_i = 1'b0;
        idle(1);
        chk_irq("ext_e2", 2'b00);
        idle(1);
        chk_irq("ext_e3", 2'b00);
        rd("ext_e3_pend", A_PEND, 32'h1);
        idle(1);
        chk_irq("ext_e4", 2'b01);
        idle(3);
        chk_irq("ext_hold", 2'b01);
        intr_ack_i = 2'b01;
        idle(1);
        intr_ack_i = 2'b00;
        chk_irq("ack_e1", 2'b01);
        rd("ack_pend", A_PEND, 32'h0);
        idle(1);
        chk_irq("ack_e2", 2'b00);

        // Timer compare rise and software clear via mtimecmp
        wr(A_IE, 32'h2);
        wr(A_MTIME, 32'h0);
        wr(A_CMP, 32'd20);
        idle(18);
        chk_irq("tmr_19_irq", 2'b00);
        rd("tmr_19_mtime", A_MTIME, 32'd19);
        idle(1);
        chk_irq("tmr_20_irq", 2'b00);
        rd("tmr_20_pend", A_PEND, 32'h2);
        idle(1);
        chk_irq("tmr_rise", 2'b10);
        wr(A_CMP, 32'hFFFF_FFFF);
        chk_irq("tmr_clr_e1", 2'b10);
        rd("tmr_clr_pend", A_PEND, 32'h0);
        idle(1);
        chk_irq("tmr_clr_e2", 2'b00);

        // mtime wrap
        wr(A_MTIME, 32'hFFFF_FFFE);
        rd("wrap_fe", A_MTIME, 32'hFFFF_FFFE);
        rd("wrap_fe_pend", A_PEND, 32'h0);
        idle(1);
        rd("wrap_ff", A_MTIME, 32'hFFFF_FFFF);
        rd("wrap_ff_pend", A_PEND, 32'h2);
        chk_irq("wrap_ff_irq", 2'b00);
        idle(1);
        rd("wrap_00", A_MTIME, 32'h0);
        rd("wrap_00_pend", A_PEND, 32'h0);
        chk_irq("wrap_00_irq", 2'b10);
        idle(1);
        chk_irq("wrap_01_irq", 2'b00);
        chk("rdata_idle", bus.bus_rdata_o, 32'h0);

        // Edge arriving with a PENDING clear: set wins
        ext_irq_i = 1'b1;
        idle(1);
        ext_irq_i = 1'b0;
        idle(1);
        wr(A_PEND, 32'h1);
        rd("setwins_pend", A_PEND, 32'h1);

        // Both pending while masked, then enable and partial disable
        wr(A_IE, 32'h0);
        wr(A_CMP, 32'h0);
        idle(1);
        chk_irq("masked_irq", 2'b00);
        rd("masked_pend", A_PEND, 32'h3);
        intr_ack_i = 2'b10;
        idle(1);
        intr_ack_i = 2'b00;
        rd("ack1_ignored", A_PEND, 32'h3);
        wr(A_IE, 32'hFFFF_FFFF);
        rd("ie_unused_bits", A_IE, 32'h3);
        chk_irq("en_e0", 2'b00);
        idle(1);
        chk_irq("en_e1", 2'b11);
        wr(A_IE, 32'h1);
        chk_irq("dis_e0", 2'b11);
        idle(1);
        chk_irq("dis_e1", 2'b01);
        rd("dis_pend_kept", A_PEND, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
